// File: rtl/myproject_div_pkg.sv
// myproject_div_pkg: shared widths, FSM state and quotient saturation limits for the sequential signed divider.
package myproject_div_pkg;
  localparam int DVD_W_DEF = 26;
  localparam int DSR_W_DEF = 16;
  localparam int QUO_W_DEF = 10;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic longint sat_hi(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint sat_lo(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/myproject_sdiv_step.sv
// myproject_sdiv_step: one restoring radix-2 step on unsigned magnitudes.
module myproject_sdiv_step
  import myproject_div_pkg::*;
#(
  parameter int W = DSR_W_DEF
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] dsr,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0] sh;
  assign sh      = {rem_in, bit_in};
  assign q_bit   = sh >= {1'b0, dsr};
  assign rem_out = W'(q_bit ? sh - {1'b0, dsr} : sh);
endmodule

// File: rtl/myproject_sdiv_seq_26s_16s_10.sv
// myproject_sdiv_seq_26s_16s_10: sequential signed restoring divider, one quotient bit per cycle.
// Define MYPROJECT_SDIV_SAT_EN to saturate an overflowing quotient instead of wrapping it.
module myproject_sdiv_seq_26s_16s_10
  import myproject_div_pkg::*;
#(
  parameter int DIVIDEND_W = DVD_W_DEF,
  parameter int DIVISOR_W  = DSR_W_DEF,
  parameter int QUOT_W     = QUO_W_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  ovf,
  output logic                  dbz
);
  localparam int CW = $clog2(DIVIDEND_W + 1);
  localparam logic signed [QUOT_W-1:0]   q_hi = QUOT_W'(sat_hi(QUOT_W));
  localparam logic signed [QUOT_W-1:0]   q_lo = QUOT_W'(sat_lo(QUOT_W));
  localparam logic signed [DIVIDEND_W:0] f_hi = (DIVIDEND_W + 1)'(sat_hi(QUOT_W));
  localparam logic signed [DIVIDEND_W:0] f_lo = (DIVIDEND_W + 1)'(sat_lo(QUOT_W));
  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [DIVIDEND_W-1:0]    dvd;
  logic [DIVISOR_W-1:0]     dsr;
  logic [DIVISOR_W-1:0]     rem_r;
  logic                     neg_q;
  logic                     neg_r;
  logic                     zdiv;
  logic [DIVIDEND_W:0]      a_ext;
  logic [DIVISOR_W:0]       b_ext;
  logic [DIVISOR_W-1:0]     rem_n;
  logic                     q_bit;
  logic [DIVIDEND_W-1:0]    qmag;
  logic signed [DIVIDEND_W:0] q_full;
  logic [DIVISOR_W-1:0]     r_full;
  logic                     ovf_n;
  logic [QUOT_W-1:0]        quot_n;
  myproject_sdiv_step #(.W(DIVISOR_W)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd[DIVIDEND_W-1]),
    .dsr     (dsr),
    .rem_out (rem_n),
    .q_bit   (q_bit)
  );
  // Sign-extend by one bit so the most negative dividend negates without wrapping.
  assign a_ext  = {din0[DIVIDEND_W-1], din0};
  assign b_ext  = {din1[DIVISOR_W-1], din1};
  assign qmag   = {dvd[DIVIDEND_W-2:0], q_bit};
  assign q_full = neg_q ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});
  assign r_full = neg_r ? -rem_n : rem_n;
  assign ovf_n  = zdiv | (q_full > f_hi) | (q_full < f_lo);
`ifdef MYPROJECT_SDIV_SAT_EN
  assign quot_n = zdiv ? (neg_r ? q_lo : q_hi) :
                  ovf_n ? (neg_q ? q_lo : q_hi) : q_full[QUOT_W-1:0];
`else
  assign quot_n = zdiv ? (neg_r ? q_lo : q_hi) : q_full[QUOT_W-1:0];
`endif
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem_r     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zdiv      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          dvd      <= DIVIDEND_W'(din0[DIVIDEND_W-1] ? -a_ext : a_ext);
          dsr      <= DIVISOR_W'(din1[DIVISOR_W-1] ? -b_ext : b_ext);
          rem_r    <= '0;
          neg_q    <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
          neg_r    <= din0[DIVIDEND_W-1];
          zdiv     <= din1 == '0;
          // A zero divisor needs no iterations; a single pass lands in DONE on the next edge.
          cnt      <= (din1 == '0) ? CW'(1) : CW'(DIVIDEND_W);
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          dvd   <= qmag;
          rem_r <= rem_n;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quot      <= quot_n;
            rem       <= zdiv ? '0 : r_full;
            ovf       <= ovf_n;
            dbz       <= zdiv;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_myproject_sdiv_seq_26s_16s_10.sv
// tb_myproject_sdiv_seq_26s_16s_10: scoreboard bench for the sequential signed divider (honours MYPROJECT_SDIV_SAT_EN).
`timescale 1ns/1ps
module tb_myproject_sdiv_seq_26s_16s_10;
  localparam int DW = 26;
  localparam int SW = 16;
  localparam int QW = 10;
  localparam longint HI = (longint'(1) << (QW - 1)) - 1;
  localparam longint LO = -(longint'(1) << (QW - 1));
  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] din0 = '0;
  logic [SW-1:0] din1 = '0;
  logic          in_ready;
  logic          out_valid;
  logic [QW-1:0] quot;
  logic [SW-1:0] rem;
  logic          ovf;
  logic          dbz;
  typedef struct {
    logic [QW-1:0] q;
    logic [SW-1:0] r;
    logic          o;
    logic          z;
    int            lat;
  } exp_t;
  exp_t sb[$];
  int n_run = 0;
  int n_fail = 0;
  myproject_sdiv_seq_26s_16s_10 dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input longint a, input longint b);
    exp_t e;
    longint q;
    if (b == 0) begin
      e.q = QW'(a >= 0 ? HI : LO);
      e.r = '0;
      e.o = 1'b1;
      e.z = 1'b1;
      e.lat = 1;
    end else begin
      q = a / b;
      e.r = SW'(a % b);
      e.o = (q > HI) || (q < LO);
      e.z = 1'b0;
      e.lat = DW;
`ifdef MYPROJECT_SDIV_SAT_EN
      e.q = e.o ? QW'(q > 0 ? HI : LO) : QW'(q);
`else
      e.q = QW'(q);
`endif
    end
    return e;
  endfunction
  task automatic run_op(input longint a, input longint b, input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    din0 = DW'(a);
    din1 = SW'(b);
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    e = sb.pop_front();
    check($sformatf("latency %0d/%0d", a, b), n, e.lat);
    check($sformatf("quot %0d/%0d", a, b), quot, e.q);
    check($sformatf("rem %0d/%0d", a, b), rem, e.r);
    check($sformatf("ovf %0d/%0d", a, b), ovf, e.o);
    check($sformatf("dbz %0d/%0d", a, b), dbz, e.z);
    repeat (hold) begin
      @(posedge ap_clk); #1;
      check("hold", {out_valid, quot, rem, ovf, dbz, in_ready}, {1'b1, e.q, e.r, e.o, e.z, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check("consumed", {out_valid, in_ready}, 2'b01);
  endtask
  initial begin
    logic signed [DW-1:0] ra;
    logic signed [SW-1:0] rb;
    bit seen;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("reset_state", {in_ready, out_valid, quot, rem, ovf, dbz}, {1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0});
    run_op(1000, 7, 0);
    run_op(-1000, 7, 0);
    run_op(1000, -7, 0);
    run_op(100000, 3, 0);
    run_op(5, 0, 0);
    run_op(-5, 0, 0);
    run_op(-33554432, -1, 0);
    run_op(1000, 7, 10);
    run_op(511 * 7 + 6, 7, 0);
    run_op(-512 * 3, 3, 0);
    run_op(-513 * 3, 3, 0);
    run_op(512, 1, 0);
    run_op(33554431, -32768, 0);
    run_op(-33554432, -32768, 0);
    run_op(-7, 32767, 0);
    run_op(0, -5, 0);
    for (int i = 0; i < 20; i++) begin
      ra = DW'($urandom);
      rb = SW'($urandom);
      if (i % 2 == 0) rb = SW'($urandom_range(40, 1)) * (i % 4 == 0 ? 1 : -1);
      run_op(ra, rb, 0);
    end
    // Abort an operation midway through CALC with an asynchronous reset.
    din0 = DW'(1000);
    din1 = SW'(7);
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1 check("reset_mid_calc", {in_ready, out_valid, quot, rem, ovf, dbz}, {1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0});
    @(negedge ap_clk) ap_rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge ap_clk); #1;
      seen |= out_valid;
    end
    check("no_spurious_valid", seen, 0);
    check("in_ready_after_reset", in_ready, 1);
    run_op(-1000, -7, 3);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/myproject_sdiv_seq_26s_16s_10.md
MYPROJECT_SDIV_SEQ_26S_16S_10 -- requirements
Module: myproject_sdiv_seq_26s_16s_10

Interface
REQ-001 SHALL provide parameter DIVIDEND_W, default 26, the signed dividend width.
REQ-002 SHALL provide parameter DIVISOR_W, default 16, the signed divisor and remainder width.
REQ-003 SHALL provide parameter QUOT_W, default 10, the signed quotient output width.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-007 SHALL have ports din0 (input, DIVIDEND_W, signed dividend) and din1 (input, DIVISOR_W, signed divisor).
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-009 SHALL have ports quot (output, QUOT_W), rem (output, DIVISOR_W), ovf (output, 1) and dbz (output, 1).

Function
REQ-010 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 SHALL drive in_ready high only in IDLE; a request is accepted on an edge where in_valid and in_ready are both high.
REQ-012 SHALL, on acceptance, register the operand magnitudes and signs, load the iteration counter with DIVIDEND_W, and enter CALC.
REQ-013 SHALL, in CALC, perform one restoring radix-2 step per cycle (shift, trial subtract, keep or restore), for exactly DIVIDEND_W cycles.
REQ-014 SHALL enter DONE and assert out_valid DIVIDEND_W edges after the acceptance edge (26 cycles at default).
REQ-015 SHALL truncate the quotient toward zero and give the remainder the sign of the dividend, with |rem| < |din1|.
REQ-016 SHALL compute the quotient at full DIVIDEND_W+1 precision and assert ovf when it lies outside [-2^(QUOT_W-1), 2^(QUOT_W-1)-1].
REQ-017 SHALL, for din1 = 0, skip CALC, enter DONE on the next edge, and set dbz=1, ovf=1, rem=0; quot is +max if din0 >= 0, else -min.
REQ-018 SHALL hold out_valid, quot, rem, ovf and dbz stable in DONE until out_ready is high, then return to IDLE on that edge.
REQ-019 SHALL NOT accept a new request in the same cycle that a result is consumed, so in_ready rises one cycle after the DONE-to-IDLE transition.
REQ-020 SHALL handle din0 = -2^(DIVIDEND_W-1) with din1 = -1 without internal wrap: the magnitude is held in DIVIDEND_W+1 bits and ovf=1.

Reset
REQ-021 SHALL, on ap_rst_n low, go to IDLE immediately and asynchronously, with in_ready=1 after release, and out_valid, quot, rem, ovf and dbz all 0.
REQ-022 SHALL, if reset is asserted in CALC or DONE, abandon the operation; no out_valid is produced for it after release.

Configuration
REQ-023 SHALL use macro MYPROJECT_SDIV_SAT_EN: when defined, an overflowing quotient saturates to 2^(QUOT_W-1)-1 or -2^(QUOT_W-1) according to the true sign.
REQ-024 SHALL, without MYPROJECT_SDIV_SAT_EN, output the low QUOT_W bits of the full-precision quotient (two's-complement wrap); ovf is reported identically in both builds, and the dbz quotient follows the same rule.

Structure
REQ-025 SHALL take the width constants, the FSM state enum and the saturation limits from shared package myproject_div_pkg.
REQ-026 SHALL place the single restoring step in sub-module myproject_sdiv_step: combinational, partial remainder and divisor in, next remainder and quotient bit out.

Verification
REQ-027 SHALL cover: 1000 / 7 -> quot=142, rem=6, ovf=0, dbz=0, out_valid exactly 26 cycles after acceptance.
REQ-028 SHALL cover: -1000 / 7 -> quot=-142, rem=-6; and 1000 / -7 -> quot=-142, rem=6.
REQ-029 SHALL cover: 100000 / 3 -> ovf=1; with SAT_EN quot=511; without SAT_EN quot=-459 (low 10 bits of 33333); rem=1 in both builds.
REQ-030 SHALL cover: 5 / 0 -> dbz=1, ovf=1, rem=0, quot=511 with SAT_EN, out_valid one cycle after acceptance; and -33554432 / -1 -> ovf=1, quot=511 with SAT_EN.
REQ-031 SHALL cover: out_ready held low for 10 cycles in DONE -> out_valid and all outputs stable, in_ready=0 throughout, in_ready=1 one cycle after consumption.
REQ-032 SHALL cover: ap_rst_n pulsed low at CALC cycle 12 -> outputs zero immediately, in_ready=1 after release, no spurious out_valid.
